lc3_mem_arbiter: RTL

Two-port arbiter and access sequencer for the LC-3 single-port 256x16 data memory. It shares the memory between the CPU controller (port 0) and a debug/program-loader port (port 1). Each access runs as a fixed MAR-load → memory-access → response sequence. The block owns the memory array and its internal MAR/MDR registers, and replaces direct MAR/MDR strobing by the CPU with a req/ack handshake.

---
 rtl/lc3_mem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: two-port round-robin arbiter and access sequencer for the
// LC-3 single-port data memory. Port 0 is the CPU, port 1 the debug/loader.
// Each access runs IDLE (grant, load MAR/MDR) -> ACCESS (memory cycle) ->
// RESP (ack pulse), so a back-to-back stream gives one access every 3 cycles.
module lc3_mem_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic [AW-1:0] mar;
    logic [15:0]   mdr;
    logic          wflag;
    logic          grant;
    logic [15:0]   mem [DEPTH];

    // Upper address bits are deliberately dropped so addresses wrap modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr0[15:AW], addr1[15:AW]};

    // Round-robin pick: a lone requester wins; on a tie the non-owner wins.
    always_comb begin
        grant = 1'b0;
        if (req0 && req1)
            grant = ~owner;
        else if (req1)
            grant = 1'b1;
    end

    // Access sequencer: grant/latch in IDLE, memory cycle in ACCESS, ack in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            owner <= 1'b1;
            mar   <= '0;
            mdr   <= '0;
            wflag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        owner <= grant;
                        mar   <= grant ? addr1[AW-1:0] : addr0[AW-1:0];
                        mdr   <= grant ? wdata1 : wdata0;
                        wflag <= grant ? we1 : we0;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // On a write MDR keeps the written data, which becomes rdata.
                    if (!wflag)
                        mdr <= mem[mar];
                    ack0  <= ~owner;
                    ack1  <= owner;
                    state <= RESP;
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory array write port; reset forces IDLE asynchronously, which cancels
    // a write whose ACCESS cycle is interrupted. Contents are never cleared.
    always_ff @(posedge clk) begin
        if (state == ACCESS && wflag)
            mem[mar] <= mdr;
    end

    assign rdata0 = mdr;
    assign rdata1 = mdr;
    assign busy   = (state != IDLE);

endmodule
